wf_bl_7seg_rx: RTL and testbench
================================

Name: wf_bl_7seg_rx

Overview:
- Serial receiver for the 3-wire 4-digit 7-segment display link (serial clock, data, load). It is the display-board end of the scan stream.
- Deserializes 16-bit frames of {segment byte, digit-select byte}, MSB first, and decodes active-low segment patterns back to hex digit values and the colon code.
- Used as a bench monitor, and to mirror or relay display contents inside the design.

Parameters:
- SYNC_STAGES, 2: synchronizer flops on each serial input; minimum 2.
- FRAME_BITS, 16: bits per frame; fixed at 16 in this revision.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- SCLK_IN  in  1  serial clock; data is valid on the rising edge.
- DIN  in  1  serial data; the source changes it on the SCLK falling edge.
- LOAD_IN  in  1  low while shifting; the rising edge latches the frame.
- digit0..digit3  out  4 each  decoded hex digit per position (0 = LSD).
- colon  out  2  last colon code received: 00 colon, 01 decpoint, 11 none.
- seg_raw  out  8  segment byte of the last frame, {DP,g,f,e,d,c,b,a}.
- sel_raw  out  8  select byte of the last frame, {colon_en,3'b000,dig[3:0]}.
- frame_valid  out  1  one-cycle pulse when a good frame is committed.
- frame_err  out  1  one-cycle pulse on a bad frame.
- decode_err  out  1  sticky; set on an unknown segment pattern; cleared by reset only.
- scan_done  out  1  one-cycle pulse when all 5 positions have been updated since the last pulse.

Behaviour:
- Reset (async, rst_n=0):
  - All digit outputs = 0; colon = 2'b11; seg_raw = 8'hFF; sel_raw = 0.
  - All pulses = 0; decode_err = 0; shift register = 0; bit count = 0; seen-mask = 0.
  - Synchronizer flops reset to SCLK=0, LOAD=1.
- Input path: each input passes through SYNC_STAGES flops. Edge detection compares the last synchronized stage with a delay flop.
- Timing requirement: SCLK high and low phases, and LOAD low, must each last at least 1 clk cycle after synchronization. SCLK = clk/2 from the same clock domain is supported.
- Shifting: on a synchronized SCLK rising edge while LOAD=0:
  - shift register <= {sr[14:0], DIN}.
  - bit count increments, saturating at 31.
  - SCLK edges while LOAD=1 are ignored.
- LOAD falling edge: bit count <= 0. The shift register is not cleared.
- LOAD rising edge (commit): seg_raw <= sr[15:8] and sel_raw <= sr[7:0] unconditionally. Then:
  - Frame good when bit count == 16 and sel[7,3:0] is one-hot with sel[6:4] == 0.
  - Otherwise frame_err pulses and no digit, colon or mask update occurs.
  - Good frame with sel[k] set (k = 0..3): digit_k <= decode(seg byte), seen-mask[k] set.
  - Good frame with sel[7] set: colon <= seg[1:0], seen-mask[4] set.
  - frame_valid pulses on a good frame.
  - Outputs update 1 cycle after the synchronized edge, i.e. SYNC_STAGES+1 cycles after the pin edge.
- Decode table (active low, {DP,g..a}; DP ignored):
  - C0→0, F9→1, A4→2, B0→3, 99→4, 92→5, 83→6, F8→7, 80→8, 98→9.
  - 88→A, A7→C, A1→D, 86→E, 8E→F.
  - Pattern 83 is shared by 6 and b and always decodes to 4'h6.
  - Any other pattern: digit unchanged, decode_err set, frame still counted as valid.
- scan_done: in the cycle the seen-mask becomes 5'h1F, scan_done pulses and the mask clears to 0. A repeated position within a scan just rewrites that position.
- Simultaneous events:
  - SCLK rise in the same cycle as LOAD rise: the shift is not taken; commit uses the pre-edge register.
  - LOAD fall and SCLK rise in the same cycle: the count resets, then this bit counts as bit 1.
- rst_n asserted mid-frame: everything returns to reset values immediately. The partial frame is discarded; the next frame begins at the next LOAD falling edge.

Decomposition:
- Package wf_7seg_pkg holds:
  - segment bit index constants and frame field positions;
  - colon code constants COLON_ON = 2'b00, DECPT = 2'b01, NONE = 2'b11;
  - the decode function (pattern → {valid, nibble}), shared with the transmit side's table.
- One sub-module: wf_sync_edge, an N-stage synchronizer with rise/fall pulse outputs. It is instantiated for SCLK_IN and LOAD_IN; DIN uses the synchronizer only.

Test Plan:
- Frame 0xC0,0x01 (16 clocks, LOAD pulse) → digit0=0, frame_valid pulse, seg_raw=C0, sel_raw=01, no error.
- Frames F9/02, A4/04, B0/08, then 0x01/0x80 → digit1=1, digit2=2, digit3=3, colon=01. scan_done pulses once, on the 5th frame only if digit0 was also written in the same scan.
- 15-bit frame, then 17-bit frame → frame_err pulse each; digits unchanged; the 17-bit frame's seg_raw/sel_raw reflect the last 16 bits.
- Select byte 0x03, then 0x10 → frame_err pulse each; no digit update.
- Segment byte 0xFF to position 2 → decode_err goes 1 and stays 1; digit2 unchanged; frame_valid pulses.
- rst_n low after 8 bits shifted, release, then a full frame 0x92/0x08 → outputs at reset values during reset, then digit3=5 with no error.

Source files
------------

// File: rtl/wf_7seg_pkg.sv
// ---------------------------------------------------------------------------
// wf_7seg_pkg
// Shared definitions for the 3-wire 4-digit 7-segment display link.
// Holds segment bit positions, frame field positions, colon codes and the
// active-low segment pattern decoder used by both the receive and transmit
// ends of the link.
// ---------------------------------------------------------------------------
package wf_7seg_pkg;

   // Segment bit positions inside the segment byte {DP,g,f,e,d,c,b,a}
   localparam int SEG_A  = 0;
   localparam int SEG_B  = 1;
   localparam int SEG_C  = 2;
   localparam int SEG_D  = 3;
   localparam int SEG_E  = 4;
   localparam int SEG_F  = 5;
   localparam int SEG_G  = 6;
   localparam int SEG_DP = 7;

   // Frame layout: {segment byte, select byte}, shifted MSB first
   localparam int FRAME_SEG_MSB = 15;
   localparam int FRAME_SEG_LSB = 8;
   localparam int FRAME_SEL_MSB = 7;
   localparam int FRAME_SEL_LSB = 0;

   // Select byte layout: {colon_en, 3'b000, dig[3:0]}
   localparam int SEL_COLON_BIT = 7;
   localparam int NUM_DIGITS    = 4;

   // Seen-mask: one bit per digit position plus one for the colon
   localparam int          NUM_POSITIONS = 5;
   localparam logic [4:0]  SCAN_ALL      = 5'h1F;

   // Colon codes carried in seg[1:0] of a colon frame
   localparam logic [1:0] COLON_ON = 2'b00;
   localparam logic [1:0] DECPT    = 2'b01;
   localparam logic [1:0] NONE     = 2'b11;

   typedef struct packed {
      logic       valid;
      logic [3:0] nibble;
   } decode_t;

   // Active-low segment pattern {g..a} back to a hex nibble. The DP bit is
   // not part of the pattern. 'b' shares its pattern with '6' and therefore
   // always comes back as 6; patterns with no digit meaning are flagged
   // invalid so the caller can leave the digit untouched.
   function automatic decode_t decodeSeg(input logic [6:0] pattern);
      decode_t result;
      result.valid  = 1'b1;
      result.nibble = 4'h0;
      case (pattern)
         7'h40:   result.nibble = 4'h0;
         7'h79:   result.nibble = 4'h1;
         7'h24:   result.nibble = 4'h2;
         7'h30:   result.nibble = 4'h3;
         7'h19:   result.nibble = 4'h4;
         7'h12:   result.nibble = 4'h5;
         7'h03:   result.nibble = 4'h6;
         7'h78:   result.nibble = 4'h7;
         7'h00:   result.nibble = 4'h8;
         7'h18:   result.nibble = 4'h9;
         7'h08:   result.nibble = 4'hA;
         7'h27:   result.nibble = 4'hC;
         7'h21:   result.nibble = 4'hD;
         7'h06:   result.nibble = 4'hE;
         7'h0E:   result.nibble = 4'hF;
         default: result.valid  = 1'b0;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/wf_sync_edge.sv
// ---------------------------------------------------------------------------
// wf_sync_edge
// N-stage synchronizer for an asynchronous single-bit input, with one-cycle
// rise/fall pulses derived from the synchronized level.
//
// Ports:
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   async_i  raw asynchronous input
//   sync_o   synchronized level (last synchronizer stage)
//   rise_o   one-cycle pulse on a synchronized 0->1 transition
//   fall_o   one-cycle pulse on a synchronized 1->0 transition
// ---------------------------------------------------------------------------
module wf_sync_edge #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic async_i,
   output logic sync_o,
   output logic rise_o,
   output logic fall_o
);

   logic [STAGES-1:0] sync_q;
   logic              dly_q;

   // Synchronizer chain plus one delay flop; every stage resets to the idle
   // level of the line so no false edge appears when reset is released.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= {STAGES{RESET_VAL}};
         dly_q  <= RESET_VAL;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], async_i};
         dly_q  <= sync_q[STAGES-1];
      end
   end

   assign sync_o = sync_q[STAGES-1];
   assign rise_o = sync_q[STAGES-1] & ~dly_q;
   assign fall_o = ~sync_q[STAGES-1] & dly_q;

endmodule

// File: rtl/wf_bl_7seg_rx.sv
// ---------------------------------------------------------------------------
// wf_bl_7seg_rx
// Display-board end of the 3-wire 7-segment scan link. Shifts in 16-bit
// {segment, select} frames MSB first on SCLK rising edges while LOAD is low,
// commits them on the LOAD rising edge, and decodes the active-low segment
// patterns back to per-position hex digits and the colon code.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   SCLK_IN           serial clock, data sampled on its rising edge
//   DIN               serial data
//   LOAD_IN           low while shifting, rising edge commits the frame
//   digit0..digit3    decoded hex digit per position (digit0 = LSD)
//   colon             last colon code (00 colon, 01 decpoint, 11 none)
//   seg_raw, sel_raw  raw segment/select bytes of the last committed frame
//   frame_valid       one-cycle pulse on a good frame
//   frame_err         one-cycle pulse on a bad frame
//   decode_err        sticky flag for an unknown segment pattern
//   scan_done         one-cycle pulse once all 5 positions were refreshed
// ---------------------------------------------------------------------------
module wf_bl_7seg_rx
   import wf_7seg_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int FRAME_BITS  = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       SCLK_IN,
   input  logic       DIN,
   input  logic       LOAD_IN,
   output logic [3:0] digit0,
   output logic [3:0] digit1,
   output logic [3:0] digit2,
   output logic [3:0] digit3,
   output logic [1:0] colon,
   output logic [7:0] seg_raw,
   output logic [7:0] sel_raw,
   output logic       frame_valid,
   output logic       frame_err,
   output logic       decode_err,
   output logic       scan_done
);

   logic sclkRise;
   logic loadRise;
   logic loadFall;
   logic loadSync;
   logic dinSync;

   logic [15:0]      sr_q,         sr_d;
   logic [4:0]       bitCnt_q,     bitCnt_d;
   logic [3:0][3:0]  digits_q,     digits_d;
   logic [1:0]       colon_q,      colon_d;
   logic [7:0]       segRaw_q,     segRaw_d;
   logic [7:0]       selRaw_q,     selRaw_d;
   logic             frameValid_q, frameValid_d;
   logic             frameErr_q,   frameErr_d;
   logic             decErr_q,     decErr_d;
   logic             scanDone_q,   scanDone_d;
   logic [4:0]       mask_q,       mask_d;

   logic [7:0]       segByte;
   logic [7:0]       selByte;
   logic             frameGood;
   logic [4:0]       maskSet;
   logic [4:0]       maskNext;
   decode_t          dec;

   // SCLK idles low and LOAD idles high, so their synchronizers reset to
   // those levels; DIN only needs the level, the edge outputs stay open.
   wf_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
      .clk     (clk),
      .rst_n   (rst_n),
      .async_i (SCLK_IN),
      .sync_o  (),
      .rise_o  (sclkRise),
      .fall_o  ()
   );

   wf_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_load (
      .clk     (clk),
      .rst_n   (rst_n),
      .async_i (LOAD_IN),
      .sync_o  (loadSync),
      .rise_o  (loadRise),
      .fall_o  (loadFall)
   );

   wf_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_din (
      .clk     (clk),
      .rst_n   (rst_n),
      .async_i (DIN),
      .sync_o  (dinSync),
      .rise_o  (),
      .fall_o  ()
   );

   // A commit always looks at the register as it stood before this cycle,
   // so an SCLK rise coinciding with the LOAD rise never sneaks into it
   // (LOAD is already high there, which also blocks the shift itself).
   assign segByte   = sr_q[FRAME_SEG_MSB:FRAME_SEG_LSB];
   assign selByte   = sr_q[FRAME_SEL_MSB:FRAME_SEL_LSB];
   assign frameGood = (bitCnt_q == 5'(FRAME_BITS)) &&
                      $onehot({selByte[SEL_COLON_BIT], selByte[NUM_DIGITS-1:0]}) &&
                      (selByte[6:4] == 3'b000);
   assign dec       = decodeSeg(segByte[SEG_G:SEG_A]);

   // Next-state for the shifter and the committed display image. The LOAD
   // fall clears the count before a simultaneous SCLK rise is added, so that
   // bit becomes bit 1 of the new frame.
   always_comb begin
      sr_d         = sr_q;
      bitCnt_d     = bitCnt_q;
      digits_d     = digits_q;
      colon_d      = colon_q;
      segRaw_d     = segRaw_q;
      selRaw_d     = selRaw_q;
      frameValid_d = 1'b0;
      frameErr_d   = 1'b0;
      scanDone_d   = 1'b0;
      decErr_d     = decErr_q;
      mask_d       = mask_q;
      maskSet      = 5'b0;
      maskNext     = mask_q;

      if (loadFall) begin
         bitCnt_d = 5'd0;
      end

      if (sclkRise && !loadSync) begin
         sr_d     = {sr_q[14:0], dinSync};
         bitCnt_d = (bitCnt_d == 5'd31) ? 5'd31 : bitCnt_d + 5'd1;
      end

      if (loadRise) begin
         segRaw_d = segByte;
         selRaw_d = selByte;
         if (frameGood) begin
            frameValid_d = 1'b1;
            if (selByte[SEL_COLON_BIT]) begin
               colon_d    = segByte[1:0];
               maskSet[4] = 1'b1;
            end else begin
               for (int k = 0; k < NUM_DIGITS; k++) begin
                  if (selByte[k]) begin
                     maskSet[k] = 1'b1;
                     if (dec.valid) begin
                        digits_d[k] = dec.nibble;
                     end else begin
                        decErr_d = 1'b1;
                     end
                  end
               end
            end
            maskNext = mask_q | maskSet;
            if (maskNext == SCAN_ALL) begin
               scanDone_d = 1'b1;
               mask_d     = 5'b0;
            end else begin
               mask_d     = maskNext;
            end
         end else begin
            frameErr_d = 1'b1;
         end
      end
   end

   // State register; reset restores the blank display image and discards
   // any partially shifted frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr_q         <= 16'h0000;
         bitCnt_q     <= 5'd0;
         digits_q     <= '0;
         colon_q      <= NONE;
         segRaw_q     <= 8'hFF;
         selRaw_q     <= 8'h00;
         frameValid_q <= 1'b0;
         frameErr_q   <= 1'b0;
         decErr_q     <= 1'b0;
         scanDone_q   <= 1'b0;
         mask_q       <= 5'b0;
      end else begin
         sr_q         <= sr_d;
         bitCnt_q     <= bitCnt_d;
         digits_q     <= digits_d;
         colon_q      <= colon_d;
         segRaw_q     <= segRaw_d;
         selRaw_q     <= selRaw_d;
         frameValid_q <= frameValid_d;
         frameErr_q   <= frameErr_d;
         decErr_q     <= decErr_d;
         scanDone_q   <= scanDone_d;
         mask_q       <= mask_d;
      end
   end

   assign digit0      = digits_q[0];
   assign digit1      = digits_q[1];
   assign digit2      = digits_q[2];
   assign digit3      = digits_q[3];
   assign colon       = colon_q;
   assign seg_raw     = segRaw_q;
   assign sel_raw     = selRaw_q;
   assign frame_valid = frameValid_q;
   assign frame_err   = frameErr_q;
   assign decode_err  = decErr_q;
   assign scan_done   = scanDone_q;

endmodule

// File: tb/tb_wf_bl_7seg_rx.sv
// ---------------------------------------------------------------------------
// tb_wf_bl_7seg_rx
// Table-driven bench for the 7-segment link receiver: each record is a
// serial frame plus the display image and pulse counts expected after it,
// followed by hand-written sequences for coincident edges and mid-frame
// reset.
// ---------------------------------------------------------------------------
module tb_wf_bl_7seg_rx;

   logic       clk;
   logic       rst_n;
   logic       SCLK_IN;
   logic       DIN;
   logic       LOAD_IN;
   logic [3:0] digit0, digit1, digit2, digit3;
   logic [1:0] colon;
   logic [7:0] seg_raw, sel_raw;
   logic       frame_valid, frame_err, decode_err, scan_done;

   int testsRun    = 0;
   int testsFailed = 0;
   int validCnt    = 0;
   int errCnt      = 0;
   int scanCnt     = 0;

   typedef struct {
      logic [31:0] bits;
      int          nBits;
      logic [15:0] expDigits;
      logic [1:0]  expColon;
      logic [7:0]  expSeg;
      logic [7:0]  expSel;
      int          expValid;
      int          expErr;
      int          expScan;
      logic        expDecErr;
   } vec_t;

   vec_t vecs[$];

   wf_bl_7seg_rx #(.SYNC_STAGES(2), .FRAME_BITS(16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .SCLK_IN     (SCLK_IN),
      .DIN         (DIN),
      .LOAD_IN     (LOAD_IN),
      .digit0      (digit0),
      .digit1      (digit1),
      .digit2      (digit2),
      .digit3      (digit3),
      .colon       (colon),
      .seg_raw     (seg_raw),
      .sel_raw     (sel_raw),
      .frame_valid (frame_valid),
      .frame_err   (frame_err),
      .decode_err  (decode_err),
      .scan_done   (scan_done)
   );

   // 100 MHz system clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse outputs are tallied on the falling edge, away from the update edge
   always @(negedge clk) begin
      if (frame_valid) validCnt++;
      if (frame_err)   errCnt++;
      if (scan_done)   scanCnt++;
   end

   task automatic waitClk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic shiftBit(input logic b);
      DIN = b;
      waitClk(2);
      SCLK_IN = 1'b1;
      waitClk(2);
      SCLK_IN = 1'b0;
   endtask

   // Plays one frame of nBits bits (MSB first) and lets the commit settle
   task automatic applyStimulus(input logic [31:0] bits, input int nBits);
      logic [31:0] v;
      v = bits;
      LOAD_IN = 1'b0;
      SCLK_IN = 1'b0;
      waitClk(3);
      for (int i = nBits - 1; i >= 0; i--) shiftBit(v[i]);
      waitClk(2);
      LOAD_IN = 1'b1;
      waitClk(8);
   endtask

   task automatic checkImage(input string tag, input logic [15:0] expDigits,
                             input logic [1:0] expColon, input logic [7:0] expSeg,
                             input logic [7:0] expSel, input logic expDecErr);
      checkOutput({tag, " digits"}, {16'h0, digit3, digit2, digit1, digit0}, {16'h0, expDigits});
      checkOutput({tag, " colon"}, {30'h0, colon}, {30'h0, expColon});
      checkOutput({tag, " seg_raw"}, {24'h0, seg_raw}, {24'h0, expSeg});
      checkOutput({tag, " sel_raw"}, {24'h0, sel_raw}, {24'h0, expSel});
      checkOutput({tag, " decode_err"}, {31'h0, decode_err}, {31'h0, expDecErr});
   endtask

   function automatic vec_t mk(input logic [31:0] bits, input int nBits,
                               input logic [15:0] dg, input logic [1:0] cl,
                               input logic [7:0] sg, input logic [7:0] sl,
                               input int v, input int e, input int s, input logic de);
      vec_t r;
      r.bits = bits;   r.nBits = nBits;  r.expDigits = dg; r.expColon = cl;
      r.expSeg = sg;   r.expSel = sl;    r.expValid = v;   r.expErr = e;
      r.expScan = s;   r.expDecErr = de;
      return r;
   endfunction

   initial begin
      int v0, e0, s0;
      string tag;

      // frame                nbits digits   col    seg    sel    v  e  s  decErr
      vecs.push_back(mk(32'hC001, 16, 16'h0000, 2'b11, 8'hC0, 8'h01, 1, 0, 0, 1'b0));
      vecs.push_back(mk(32'hF902, 16, 16'h0010, 2'b11, 8'hF9, 8'h02, 1, 0, 0, 1'b0));
      vecs.push_back(mk(32'hA404, 16, 16'h0210, 2'b11, 8'hA4, 8'h04, 1, 0, 0, 1'b0));
      vecs.push_back(mk(32'hB008, 16, 16'h3210, 2'b11, 8'hB0, 8'h08, 1, 0, 0, 1'b0));
      vecs.push_back(mk(32'h0180, 16, 16'h3210, 2'b01, 8'h01, 8'h80, 1, 0, 1, 1'b0));
      vecs.push_back(mk(32'h1201, 15, 16'h3210, 2'b01, 8'h12, 8'h01, 0, 1, 0, 1'b0));
      vecs.push_back(mk(32'h19201, 17, 16'h3210, 2'b01, 8'h92, 8'h01, 0, 1, 0, 1'b0));
      vecs.push_back(mk(32'hF903, 16, 16'h3210, 2'b01, 8'hF9, 8'h03, 0, 1, 0, 1'b0));
      vecs.push_back(mk(32'hF910, 16, 16'h3210, 2'b01, 8'hF9, 8'h10, 0, 1, 0, 1'b0));
      vecs.push_back(mk(32'hFF04, 16, 16'h3210, 2'b01, 8'hFF, 8'h04, 1, 0, 0, 1'b1));
      vecs.push_back(mk(32'h8601, 16, 16'h321E, 2'b01, 8'h86, 8'h01, 1, 0, 0, 1'b1));
      vecs.push_back(mk(32'h8E02, 16, 16'h32FE, 2'b01, 8'h8E, 8'h02, 1, 0, 0, 1'b1));
      vecs.push_back(mk(32'h8308, 16, 16'h62FE, 2'b01, 8'h83, 8'h08, 1, 0, 0, 1'b1));
      vecs.push_back(mk(32'h0080, 16, 16'h62FE, 2'b00, 8'h00, 8'h80, 1, 0, 1, 1'b1));
      vecs.push_back(mk(32'h8801, 16, 16'h62FA, 2'b00, 8'h88, 8'h01, 1, 0, 0, 1'b1));
      vecs.push_back(mk(32'hA702, 16, 16'h62CA, 2'b00, 8'hA7, 8'h02, 1, 0, 0, 1'b1));
      vecs.push_back(mk(32'hA104, 16, 16'h6DCA, 2'b00, 8'hA1, 8'h04, 1, 0, 0, 1'b1));
      vecs.push_back(mk(32'h9908, 16, 16'h4DCA, 2'b00, 8'h99, 8'h08, 1, 0, 0, 1'b1));
      vecs.push_back(mk(32'h9801, 16, 16'h4DC9, 2'b00, 8'h98, 8'h01, 1, 0, 0, 1'b1));
      vecs.push_back(mk(32'h8008, 16, 16'h8DC9, 2'b00, 8'h80, 8'h08, 1, 0, 0, 1'b1));
      vecs.push_back(mk(32'hFF80, 16, 16'h8DC9, 2'b11, 8'hFF, 8'h80, 1, 0, 1, 1'b1));
      vecs.push_back(mk(32'h4002, 16, 16'h8D09, 2'b11, 8'h40, 8'h02, 1, 0, 0, 1'b1));

      rst_n   = 1'b0;
      SCLK_IN = 1'b0;
      DIN     = 1'b0;
      LOAD_IN = 1'b1;
      waitClk(3);
      checkImage("reset", 16'h0000, 2'b11, 8'hFF, 8'h00, 1'b0);
      checkOutput("reset pulses", {29'h0, frame_valid, frame_err, scan_done}, 32'h0);
      rst_n = 1'b1;
      waitClk(3);

      for (int i = 0; i < vecs.size(); i++) begin
         v0 = validCnt; e0 = errCnt; s0 = scanCnt;
         applyStimulus(vecs[i].bits, vecs[i].nBits);
         tag = $sformatf("vec%0d", i);
         checkImage(tag, vecs[i].expDigits, vecs[i].expColon, vecs[i].expSeg,
                    vecs[i].expSel, vecs[i].expDecErr);
         checkOutput({tag, " valid pulses"}, validCnt - v0, vecs[i].expValid);
         checkOutput({tag, " err pulses"}, errCnt - e0, vecs[i].expErr);
         checkOutput({tag, " scan pulses"}, scanCnt - s0, vecs[i].expScan);
      end

      // SCLK rise together with LOAD rise: the 17th bit must not be shifted
      v0 = validCnt; e0 = errCnt;
      LOAD_IN = 1'b0;
      SCLK_IN = 1'b0;
      waitClk(3);
      begin
         logic [15:0] f;
         f = 16'hF901;
         for (int i = 15; i >= 0; i--) shiftBit(f[i]);
      end
      DIN = 1'b1;
      waitClk(2);
      SCLK_IN = 1'b1;
      LOAD_IN = 1'b1;
      waitClk(8);
      SCLK_IN = 1'b0;
      waitClk(2);
      checkImage("sclk+load rise", 16'h8D01, 2'b11, 8'hF9, 8'h01, 1'b1);
      checkOutput("sclk+load rise valid", validCnt - v0, 1);
      checkOutput("sclk+load rise err", errCnt - e0, 0);

      // LOAD fall together with SCLK rise: that bit is bit 1 of the frame
      v0 = validCnt; e0 = errCnt;
      begin
         logic [15:0] f;
         f = 16'hA404;
         DIN = f[15];
         waitClk(2);
         LOAD_IN = 1'b0;
         SCLK_IN = 1'b1;
         waitClk(2);
         SCLK_IN = 1'b0;
         for (int i = 14; i >= 0; i--) shiftBit(f[i]);
      end
      waitClk(2);
      LOAD_IN = 1'b1;
      waitClk(8);
      checkImage("load fall+sclk rise", 16'h8201, 2'b11, 8'hA4, 8'h04, 1'b1);
      checkOutput("load fall+sclk rise valid", validCnt - v0, 1);
      checkOutput("load fall+sclk rise err", errCnt - e0, 0);

      // Reset asserted after 8 bits of a frame
      LOAD_IN = 1'b0;
      SCLK_IN = 1'b0;
      waitClk(3);
      for (int i = 0; i < 8; i++) shiftBit(i[0]);
      rst_n = 1'b0;
      #2;
      checkImage("mid-frame reset", 16'h0000, 2'b11, 8'hFF, 8'h00, 1'b0);
      LOAD_IN = 1'b1;
      SCLK_IN = 1'b0;
      waitClk(3);
      checkOutput("mid-frame reset pulses", {29'h0, frame_valid, frame_err, scan_done}, 32'h0);
      rst_n = 1'b1;
      waitClk(3);
      v0 = validCnt; e0 = errCnt;
      applyStimulus(32'h9208, 16);
      checkImage("after reset", 16'h5000, 2'b11, 8'h92, 8'h08, 1'b0);
      checkOutput("after reset valid", validCnt - v0, 1);
      checkOutput("after reset err", errCnt - e0, 0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
